arbitro_memoria_dados: RTL
==========================

Name: arbitro_memoria_dados

Overview:
- Shares the single data-memory port between two requesters:
  - the pipeline MEM stage (CPU), which is the default owner;
  - the UART debug/loader engine, which reads and writes data memory while the core runs.
- Sits between the MEM-stage signals (read/write strobes, word address, store data) and the data-memory instance.
- Returns a stall to the pipeline when the UART holds the port.
- Uses a starvation counter so the UART is always served eventually.

Parameters:
ADDR_W, 7, word-address width (memory byte address bits [8:2]).
DATA_W, 32, data width.
MAX_ESPERA, 8, cycles the UART may be blocked by CPU traffic before a forced grant (1..255).

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
cpu_ler  in  1  MEM-stage read strobe.
cpu_escrever  in  1  MEM-stage write strobe.
cpu_endereco  in  ADDR_W  MEM-stage word address.
cpu_dado_escrever  in  DATA_W  MEM-stage store data.
cpu_dado_ler  out  DATA_W  load data to MEM/WB register (mem_dado_ler pass-through).
cpu_parada  out  1  stall request to pipeline; MEM stage and all earlier stages hold while high.
uart_req  in  1  UART access request; held with its operands until uart_ack.
uart_escrever  in  1  1 = write, 0 = read.
uart_endereco  in  ADDR_W  UART word address.
uart_dado_escrever  in  DATA_W  UART write data.
uart_ack  out  1  one-cycle completion pulse (registered).
uart_dado_ler  out  DATA_W  registered read data; valid while uart_ack=1 and held until the next UART read.
mem_ler, mem_escrever  out  1 each  memory strobes.
mem_endereco  out  ADDR_W  memory address.
mem_dado_escrever  out  DATA_W  memory write data.
mem_dado_ler  in  DATA_W  combinational memory read data; memory writes on posedge.

Behaviour:
- cpu_acesso = cpu_ler | cpu_escrever.
- States: CPU (default), UART, ACK; 2-bit registered state.
- Reset:
  - state=CPU, espera=0, uart_ack=0, uart_dado_ler=0.
  - While reset=1, mem_ler and mem_escrever are forced to 0 regardless of state.
- CPU state:
  - mem_* driven from cpu_* inputs combinationally; cpu_parada=0.
  - Next state = UART when uart_req=1 and (cpu_acesso=0 or espera==MAX_ESPERA); otherwise stay in CPU.
- espera counter:
  - In CPU state, increments (saturating at MAX_ESPERA) each cycle that uart_req=1 and cpu_acesso=1.
  - Clears on entry to UART.
- Forced grant: the CPU access in the current cycle still completes; only the next cycle's CPU access sees the stall.
- UART state (exactly 1 cycle):
  - mem_* driven from uart_*; mem_ler = ~uart_escrever, mem_escrever = uart_escrever.
  - cpu_parada = cpu_acesso (combinational); the CPU strobes never reach memory this cycle.
  - On the edge: a read captures mem_dado_ler into uart_dado_ler; a write leaves uart_dado_ler unchanged. uart_ack<=1; next = ACK.
  - If uart_req=0 on entry (protocol violation): mem strobes 0, no ack, next = CPU, espera=0.
- ACK state:
  - uart_ack=1; CPU owns the port; cpu_parada=0.
  - uart_req is ignored this cycle (the requester deasserts in response to the ack).
  - Next = CPU; uart_ack<=0.
- Latency:
  - UART access with an idle CPU: req at cycle n, grant n+1, ack n+2.
  - Minimum spacing between UART grants is 3 cycles.
- CPU throughput: at most one stall cycle per UART access. The CPU is never stalled in CPU or ACK state.
- cpu_ler=cpu_escrever=1 is illegal; both strobes are passed through unmodified.
- Reset asserted in UART state suppresses that write, drops the ack, and returns to CPU.

Test Plan:
1. Idle UART: CPU write 0xDEADBEEF to addr 5, then read addr 5 -> cpu_dado_ler=0xDEADBEEF, cpu_parada never 1.
2. UART write with idle CPU: req at cycle 0 (addr 9, 0x12345678) -> mem_escrever=1 at cycle 1, uart_ack=1 at cycle 2 only; CPU read of addr 9 afterwards returns 0x12345678.
3. Contention: CPU accesses every cycle, UART read of addr 3 pending, MAX_ESPERA=8 -> espera counts 1..8, grant on the following cycle with cpu_parada=1 for exactly that cycle, uart_ack next cycle, uart_dado_ler = mem[3].
4. CPU idle in the grant cycle: UART read while cpu_acesso=0 -> cpu_parada stays 0 throughout, ack 2 cycles after req.
5. Back-to-back UART requests: req held high through ACK and reasserted -> second grant no earlier than 3 cycles after the first, and uart_ack never high two consecutive cycles.
6. Reset in UART state during a write to addr 2 (old value 0x0) -> mem[2] stays 0x0, uart_ack=0, state=CPU, espera=0 after the reset cycle.

Source files
------------

// File: rtl/arbitro_memoria_dados.sv
// Data-memory port arbiter between the MEM stage (default owner) and the UART debug/loader engine.
// The UART gets a one-cycle grant, followed by an ack cycle. A starvation counter forces a grant under heavy CPU traffic.
`timescale 1ns/1ps
module arbitro_memoria_dados #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_ESPERA = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_ler,
  input  logic              cpu_escrever,
  input  logic [ADDR_W-1:0] cpu_endereco,
  input  logic [DATA_W-1:0] cpu_dado_escrever,
  output logic [DATA_W-1:0] cpu_dado_ler,
  output logic              cpu_parada,
  input  logic              uart_req,
  input  logic              uart_escrever,
  input  logic [ADDR_W-1:0] uart_endereco,
  input  logic [DATA_W-1:0] uart_dado_escrever,
  output logic              uart_ack,
  output logic [DATA_W-1:0] uart_dado_ler,
  output logic              mem_ler,
  output logic              mem_escrever,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dado_escrever,
  input  logic [DATA_W-1:0] mem_dado_ler
);

  localparam int unsigned ESPERA_W = 8;
  localparam logic [ESPERA_W-1:0] ESPERA_MAX = ESPERA_W'(MAX_ESPERA);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_UART = 2'd1,
    ST_ACK  = 2'd2
  } estado_t;

  estado_t             estado, estado_prox;
  logic [ESPERA_W-1:0] espera, espera_prox;
  logic                ack_prox;
  logic [DATA_W-1:0]   dado_prox;
  logic                cpu_acesso;

  assign cpu_acesso   = cpu_ler | cpu_escrever;
  assign cpu_dado_ler = mem_dado_ler;

  // State, starvation counter and registered UART outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= ST_CPU;
      espera        <= '0;
      uart_ack      <= 1'b0;
      uart_dado_ler <= '0;
    end else begin
      estado        <= estado_prox;
      espera        <= espera_prox;
      uart_ack      <= ack_prox;
      uart_dado_ler <= dado_prox;
    end
  end

  // Next state, port mux and stall
  always_comb begin
    estado_prox       = estado;
    espera_prox       = espera;
    ack_prox          = 1'b0;
    dado_prox         = uart_dado_ler;
    cpu_parada        = 1'b0;
    mem_ler           = cpu_ler;
    mem_escrever      = cpu_escrever;
    mem_endereco      = cpu_endereco;
    mem_dado_escrever = cpu_dado_escrever;

    unique case (estado)
      ST_CPU: begin
        if (uart_req && cpu_acesso && (espera != ESPERA_MAX)) begin
          espera_prox = espera + ESPERA_W'(1);
        end
        if (uart_req && (!cpu_acesso || (espera == ESPERA_MAX))) begin
          estado_prox = ST_UART;
          espera_prox = '0;
        end
      end
      ST_UART: begin
        mem_endereco      = uart_endereco;
        mem_dado_escrever = uart_dado_escrever;
        cpu_parada        = cpu_acesso;
        espera_prox       = '0;
        if (uart_req) begin
          mem_ler      = ~uart_escrever;
          mem_escrever = uart_escrever;
          ack_prox     = 1'b1;
          estado_prox  = ST_ACK;
          if (!uart_escrever) begin
            dado_prox = mem_dado_ler;
          end
        end else begin
          // Request vanished before the grant: release the port without an ack
          mem_ler      = 1'b0;
          mem_escrever = 1'b0;
          estado_prox  = ST_CPU;
        end
      end
      ST_ACK: begin
        estado_prox = ST_CPU;
      end
      default: begin
        estado_prox = ST_CPU;
      end
    endcase

    if (reset) begin
      mem_ler      = 1'b0;
      mem_escrever = 1'b0;
    end
  end

endmodule
